// File: rtl/ring_mod_sequencer.sv
// ring_mod_sequencer
//   Initiator side of the ring-modulator start/ready handshake. It takes one
//   carrier/modulator sample pair per output period, launches a single
//   multiply on the ring-mod responder, waits for the result and presents one
//   16-bit sample to the DAC output formatter. A watchdog bounds how long it
//   waits on the responder. When it expires, the clamped dry sample is sent
//   instead and a sticky timeout flag is raised.
//
//   Optional feature macro: RING_MOD_MIX_EN. When it is defined, the output is
//   a dry/wet blend weighted by i_Mix. When it is undefined, the output is the
//   wet result and i_Mix is ignored. The latency is the same in both builds.
//
// Ports
//   i_Clock          system clock, rising edge
//   i_Reset_n        synchronous reset, active low
//   i_Sample1/2      signed 20-bit carrier (also the dry path) / modulator
//   i_Sample_Valid   one-cycle strobe for a sample pair
//   o_Busy           high from the accepted strobe through the o_Out_Valid cycle
//   o_RM_Sample1/2   registered sample pair driven to the responder
//   o_RM_Start       one-cycle start pulse to the responder
//   i_RM_Ready       responder ready (high when idle or when the result is valid)
//   i_RM_Result      responder result, signed 16-bit
//   i_Mix            wet amount, 0 = all dry, 255 = all wet (mix build only)
//   o_Out_Sample     signed output sample, held between updates
//   o_Out_Valid      one-cycle strobe marking an o_Out_Sample update
//   o_Timeout        sticky responder-failure flag, cleared only by reset
module ring_mod_sequencer #(
  parameter logic signed [19:0] SAMPLE_OFFSET  = 20'sh7FFF,
  parameter int                 TIMEOUT_CYCLES = 64
) (
  input  logic        i_Clock,
  input  logic        i_Reset_n,
  input  logic [19:0] i_Sample1,
  input  logic [19:0] i_Sample2,
  input  logic        i_Sample_Valid,
  output logic        o_Busy,
  output logic [19:0] o_RM_Sample1,
  output logic [19:0] o_RM_Sample2,
  output logic        o_RM_Start,
  input  logic        i_RM_Ready,
  input  logic [15:0] i_RM_Result,
  input  logic [7:0]  i_Mix,
  output logic [15:0] o_Out_Sample,
  output logic        o_Out_Valid,
  output logic        o_Timeout
);

  // state | meaning
  // IDLE  | waiting for a sample strobe while the responder is ready
  // START | start pulse on the responder; watchdog armed
  // ACK   | waiting for the responder to drop ready (request taken)
  // WAIT  | waiting for ready to return high with the result
  // BLEND | forming the output sample from the wet/dry values
  // OUT   | o_Out_Valid high for this cycle; busy clears on exit
  typedef enum logic [2:0] {IDLE, START, ACK, WAIT, BLEND, OUT} state_t;

  localparam int                 WD_W       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0]    WD_LOAD    = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic signed [19:0] NEG_OFFSET = -SAMPLE_OFFSET;
  localparam logic [15:0]        LIM_HI     = SAMPLE_OFFSET[15:0];
  localparam logic [15:0]        LIM_LO     = NEG_OFFSET[15:0];

  state_t            state;
  logic [WD_W-1:0]   wdog;
  logic [15:0]       wet_q;
  logic [15:0]       dry;
  logic [15:0]       blend_out;

  always_comb begin
    if ($signed(o_RM_Sample1) > SAMPLE_OFFSET)
      dry = LIM_HI;
    else if ($signed(o_RM_Sample1) < NEG_OFFSET)
      dry = LIM_LO;
    else
      dry = o_RM_Sample1[15:0];
  end

`ifdef RING_MOD_MIX_EN
  localparam logic signed [24:0] SAT_HI = SAMPLE_OFFSET;
  localparam logic signed [24:0] SAT_LO = NEG_OFFSET;

  logic signed [24:0] wet_x, dry_x, mix_w, mix_d, mix_sum, mix_shr;

  always_comb begin
    wet_x   = 25'($signed(wet_q));
    dry_x   = 25'($signed(dry));
    mix_w   = 25'({1'b0, i_Mix});
    // 255 - i_Mix is the bitwise complement of an 8-bit value.
    mix_d   = 25'({1'b0, ~i_Mix});
    mix_sum = wet_x * mix_w + dry_x * mix_d;
    mix_shr = mix_sum >>> 8;
    if (mix_shr > SAT_HI)
      blend_out = LIM_HI;
    else if (mix_shr < SAT_LO)
      blend_out = LIM_LO;
    else
      blend_out = mix_shr[15:0];
  end
`else
  logic unused_mix;
  assign unused_mix = ^i_Mix;
  assign blend_out  = wet_q;
`endif

  // The watchdog is a down-counter. It is loaded in START, and reaching zero
  // while still in ACK/WAIT means TIMEOUT_CYCLES cycles have elapsed.
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      state        <= IDLE;
      wdog         <= '0;
      wet_q        <= '0;
      o_Busy       <= 1'b0;
      o_RM_Sample1 <= '0;
      o_RM_Sample2 <= '0;
      o_RM_Start   <= 1'b0;
      o_Out_Sample <= '0;
      o_Out_Valid  <= 1'b0;
      o_Timeout    <= 1'b0;
    end else begin
      o_RM_Start  <= 1'b0;
      o_Out_Valid <= 1'b0;
      case (state)
        IDLE: begin
          if (i_Sample_Valid && i_RM_Ready) begin
            o_RM_Sample1 <= i_Sample1;
            o_RM_Sample2 <= i_Sample2;
            o_Busy       <= 1'b1;
            o_RM_Start   <= 1'b1;
            state        <= START;
          end
        end
        START: begin
          wdog  <= WD_LOAD;
          state <= ACK;
        end
        ACK: begin
          // Ready may still be high from before the request. Only the drop
          // to low counts as acceptance.
          if (wdog == '0) begin
            o_Timeout    <= 1'b1;
            o_Out_Sample <= dry;
            o_Out_Valid  <= 1'b1;
            state        <= OUT;
          end else begin
            wdog <= wdog - 1'b1;
            if (!i_RM_Ready)
              state <= WAIT;
          end
        end
        WAIT: begin
          if (i_RM_Ready) begin
            wet_q <= i_RM_Result;
            state <= BLEND;
          end else if (wdog == '0) begin
            o_Timeout    <= 1'b1;
            o_Out_Sample <= dry;
            o_Out_Valid  <= 1'b1;
            state        <= OUT;
          end else begin
            wdog <= wdog - 1'b1;
          end
        end
        BLEND: begin
          o_Out_Sample <= blend_out;
          o_Out_Valid  <= 1'b1;
          state        <= OUT;
        end
        OUT: begin
          // The abort path also passes through here, so busy covers the
          // valid cycle and no new pair can land on the same cycle.
          o_Busy <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ring_mod_sequencer.sv
module tb_ring_mod_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [19:0] s1, s2;
  logic        sv;
  logic        busy;
  logic [19:0] rm_s1, rm_s2;
  logic        rm_start;
  logic        rm_ready;
  logic [15:0] rm_result;
  logic [7:0]  mix;
  logic [15:0] out_sample;
  logic        out_valid;
  logic        timeout_flag;

  always #5 clk = ~clk;

  ring_mod_sequencer dut (
    .i_Clock        (clk),
    .i_Reset_n      (rst_n),
    .i_Sample1      (s1),
    .i_Sample2      (s2),
    .i_Sample_Valid (sv),
    .o_Busy         (busy),
    .o_RM_Sample1   (rm_s1),
    .o_RM_Sample2   (rm_s2),
    .o_RM_Start     (rm_start),
    .i_RM_Ready     (rm_ready),
    .i_RM_Result    (rm_result),
    .i_Mix          (mix),
    .o_Out_Sample   (out_sample),
    .o_Out_Valid    (out_valid),
    .o_Timeout      (timeout_flag)
  );

`ifdef RING_MOD_MIX_EN
  localparam bit MIX_ON = 1'b1;
`else
  localparam bit MIX_ON = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Responder model: it reacts one cycle after seeing start, holds ready low
  // for 6 cycles, then raises ready together with the result. Mode 1 keeps
  // ready stuck high and mode 2 keeps it stuck low.
  int          resp_mode  = 0;
  logic [15:0] resp_value = 16'h0;
  logic        rdy_q, react;
  int          lowcnt;

  always @(posedge clk) begin
    if (!rst_n) begin
      rdy_q     <= 1'b1;
      react     <= 1'b0;
      lowcnt    <= 0;
      rm_result <= 16'hDEAD;
    end else begin
      react <= rm_start;
      if (react) begin
        rdy_q     <= 1'b0;
        lowcnt    <= 5;
        rm_result <= 16'hDEAD;
      end else if (!rdy_q) begin
        if (lowcnt == 0) begin
          rdy_q     <= 1'b1;
          rm_result <= resp_value;
        end else begin
          lowcnt <= lowcnt - 1;
        end
      end
    end
  end

  assign rm_ready = (resp_mode == 1) ? 1'b1 : (resp_mode == 2) ? 1'b0 : rdy_q;

  int n_start = 0;
  int n_valid = 0;
  always @(negedge clk) begin
    if (rm_start)  n_start++;
    if (out_valid) n_valid++;
  end

  function automatic int dry_of(input logic [19:0] v);
    int x;
    x = int'($signed(v));
    if (x > 32767)  x = 32767;
    if (x < -32767) x = -32767;
    return x;
  endfunction

  function automatic int ref_out(input logic [15:0] wet, input logic [19:0] v, input logic [7:0] m);
    int w, acc;
    w   = int'($signed(wet));
    acc = (w * int'(m) + dry_of(v) * (255 - int'(m))) >>> 8;
    if (acc > 32767)  acc = 32767;
    if (acc < -32767) acc = -32767;
    return MIX_ON ? acc : w;
  endfunction

  bit exp_to = 1'b0;

  task automatic txn(input logic [19:0] a, input logic [19:0] b, input logic [15:0] res,
                     input logic [7:0] m, input bit stuck, input bit dup, input string tag);
    int st0, va0, k, exp_lat, exp_int;
    bit seen;
    logic [15:0] exp_o;
    resp_mode  = stuck ? 1 : 0;
    resp_value = res;
    mix        = m;
    @(negedge clk);
    s1 = a; s2 = b; sv = 1'b1;
    @(posedge clk);
    #1 sv = 1'b0;
    st0 = n_start; va0 = n_valid;
    exp_lat = stuck ? 65 : 10;
    exp_int = stuck ? dry_of(a) : ref_out(res, a, m);
    exp_o   = exp_int[15:0];
    if (stuck) exp_to = 1'b1;
    seen = 1'b0; k = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (i == 0) begin
        check({tag, "_busy_start"}, busy, 1);
        check({tag, "_rm_s1"}, rm_s1, a);
        check({tag, "_rm_s2"}, rm_s2, b);
      end
      if (i == 5) check({tag, "_busy_mid"}, busy, 1);
      if (dup && i == 3) begin
        s1 = ~a; s2 = ~b; sv = 1'b1;
      end
      if (i == 4) sv = 1'b0;
      if (out_valid) begin
        seen = 1'b1; k = i;
        break;
      end
    end
    sv = 1'b0;
    check({tag, "_latency"}, seen ? k : -1, exp_lat);
    check({tag, "_out"}, out_sample, exp_o);
    check({tag, "_timeout"}, timeout_flag, exp_to);
    @(negedge clk);
    check({tag, "_valid_drop"}, out_valid, 0);
    check({tag, "_busy_drop"}, busy, 0);
    check({tag, "_n_start"}, n_start - st0, 1);
    check({tag, "_n_valid"}, n_valid - va0, 1);
    resp_mode = 0;
  endtask

  initial begin
    int st0, va0, gap;
    rst_n = 1'b0; sv = 1'b1; s1 = 20'h12345; s2 = 20'h0ABCD; mix = 8'd128;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out", out_sample, 0);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_start", rm_start, 0);
    check("rst_timeout", timeout_flag, 0);
    check("rst_rm_s1", rm_s1, 0);
    check("rst_n_start", n_start, 0);
    rst_n = 1'b1; sv = 1'b0;
    repeat (2) @(negedge clk);

    txn(20'h04000, 20'h02000, 16'h1000, 8'd255, 0, 0, "basic");
    txn(20'hFFFFF, 20'h00001, 16'h4000, 8'd0,   0, 0, "dry_neg1");
    txn(20'h01234, 20'h05678, 16'h2222, 8'd77,  0, 1, "dup");

    // Strobe while the responder reports not-ready must be dropped.
    resp_mode = 2;
    @(negedge clk);
    s1 = 20'h00111; sv = 1'b1;
    @(posedge clk);
    #1 sv = 1'b0;
    st0 = n_start;
    repeat (5) @(negedge clk);
    check("drop_n_start", n_start - st0, 0);
    check("drop_busy", busy, 0);
    resp_mode = 0;
    @(negedge clk);

    for (int r = 0; r < 20; r++) begin
      txn(20'($urandom), 20'($urandom), 16'($urandom), 8'($urandom), 0, 0, "rand");
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
    end
    txn(20'h80000, 20'h00010, 16'h8000, 8'd0,   0, 0, "neg_clamp");

    txn(20'h10000, 20'h00020, 16'h5555, 8'd200, 1, 0, "timeout");
    repeat (8) @(negedge clk);
    txn(20'h00400, 20'h00300, 16'h3C3C, 8'd100, 0, 0, "after_to");

    // Reset while the sequencer is waiting on the responder.
    @(negedge clk);
    s1 = 20'h00777; s2 = 20'h00888; sv = 1'b1; resp_value = 16'h7777;
    @(posedge clk);
    #1 sv = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rstwait_out", out_sample, 0);
    check("rstwait_busy", busy, 0);
    check("rstwait_timeout", timeout_flag, 0);
    rst_n = 1'b1;
    exp_to = 1'b0;
    va0 = n_valid;
    repeat (15) @(negedge clk);
    check("rstwait_no_valid", n_valid - va0, 0);
    txn(20'h00ABC, 20'h00DEF, 16'hF00D, 8'd33, 0, 0, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
